// File: rtl/dlx_sram_ctrl.sv
// ---------------------------------------------------------------------------
// dlx_sram_ctrl
//
// Purpose:
//   Bridges the DLX core's 32-bit word memory port to the board's 1M x 16
//   asynchronous SRAM. Every core request is split into two 16-bit SRAM
//   accesses, lower half first and then upper half. Halves that a write does
//   not touch at all (both byte enables clear) are skipped. The request side
//   uses a req/ack handshake: req is only looked at while idle, and ack is a
//   single-cycle pulse once the whole word has been transferred.
//
//   Every SRAM-facing output comes straight from a flop. The values are
//   computed from the *next* state, so the pins are glitch free and still
//   line up cycle-for-cycle with the state machine.
//
// Parameters:
//   ADDR_W       word-address width; sram_addr is ADDR_W+1 bits (half-words)
//   WAIT_CYCLES  strobe cycles per half access, legal range 1..15
//
// Ports:
//   clk, rst_n     single clock, synchronous active-low reset
//   req, we, addr, be, wdata
//                  core request; we/addr/be/wdata are captured with req
//   rdata, ack     read data (valid with ack) and completion pulse
//   busy           high whenever the controller is not idle
//   sram_addr      half-word address {addr, half}
//   sram_dq_o      write data towards the SRAM
//   sram_dq_oe     1 = drive the SRAM data bus (tristate is in the top level)
//   sram_dq_i      read data from the SRAM
//   sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
//                  active-low SRAM strobes
// ---------------------------------------------------------------------------
module dlx_sram_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W:0]   sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LO_SETUP = 3'd1,
    LO_STB   = 3'd2,
    HI_SETUP = 3'd3,
    HI_STB   = 3'd4,
    DONE     = 3'd5
  } state_t;

  // The strobe counter runs 0..WAIT_CYCLES-1 inside each STB state.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;

  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [ADDR_W:0]     sram_addr_q, sram_addr_d;
  logic [15:0]         sram_dq_o_q, sram_dq_o_d;
  logic                sram_dq_oe_q, sram_dq_oe_d;
  logic                sram_ce_n_q, sram_ce_n_d;
  logic                sram_oe_n_q, sram_oe_n_d;
  logic                sram_we_n_q, sram_we_n_d;
  logic                sram_lb_n_q, sram_lb_n_d;
  logic                sram_ub_n_q, sram_ub_n_d;

  logic                next_in_lo;
  logic                next_in_hi;
  logic                next_in_stb;

  // Next-state logic. The request fields are captured only in IDLE, so any
  // activity on the request inputs while busy is invisible to the sequencer.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          be_d    = be;
          wdata_d = wdata;
          // A write that touches no byte of the lower half skips it; with
          // no enables at all there is nothing to access, so go straight
          // to the ack.
          if (we && (be[1:0] == 2'b00)) begin
            state_d = (be[3:2] == 2'b00) ? DONE : HI_SETUP;
          end else begin
            state_d = LO_SETUP;
          end
        end
      end

      LO_SETUP: begin
        state_d    = LO_STB;
        wait_cnt_d = '0;
      end

      LO_STB: begin
        if (wait_cnt_q == LAST_CNT) begin
          wait_cnt_d = '0;
          // The SRAM has been driving the bus for the whole strobe window,
          // so the exit edge is the latest and safest sample point.
          if (!we_q) begin
            rdata_d[15:0] = sram_dq_i;
          end
          state_d = (we_q && (be_q[3:2] == 2'b00)) ? DONE : HI_SETUP;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      HI_SETUP: begin
        state_d    = HI_STB;
        wait_cnt_d = '0;
      end

      HI_STB: begin
        if (wait_cnt_q == LAST_CNT) begin
          wait_cnt_d = '0;
          if (!we_q) begin
            rdata_d[31:16] = sram_dq_i;
          end
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered pins change on the
  // same edge as the state register. Address and write data are held when
  // no access is under way; the strobes are what qualify them.
  always_comb begin
    next_in_lo  = (state_d == LO_SETUP) || (state_d == LO_STB);
    next_in_hi  = (state_d == HI_SETUP) || (state_d == HI_STB);
    next_in_stb = (state_d == LO_STB)   || (state_d == HI_STB);

    ack_d        = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    sram_addr_d  = sram_addr_q;
    sram_dq_o_d  = sram_dq_o_q;
    sram_dq_oe_d = 1'b0;
    sram_ce_n_d  = 1'b1;
    sram_oe_n_d  = 1'b1;
    sram_we_n_d  = 1'b1;
    sram_lb_n_d  = 1'b1;
    sram_ub_n_d  = 1'b1;

    if (next_in_lo || next_in_hi) begin
      sram_ce_n_d = 1'b0;
      sram_addr_d = {addr_d, next_in_hi};
      if (we_d) begin
        // Writes drive the bus for the whole half access and only enable
        // the byte lanes the core asked for.
        sram_dq_oe_d = 1'b1;
        sram_dq_o_d  = next_in_hi ? wdata_d[31:16] : wdata_d[15:0];
        sram_lb_n_d  = next_in_hi ? ~be_d[2] : ~be_d[0];
        sram_ub_n_d  = next_in_hi ? ~be_d[3] : ~be_d[1];
        if (next_in_stb) begin
          sram_we_n_d = 1'b0;
        end
      end else begin
        // Reads always fetch both bytes; the core picks what it needs.
        sram_lb_n_d = 1'b0;
        sram_ub_n_d = 1'b0;
        if (next_in_stb) begin
          sram_oe_n_d = 1'b0;
        end
      end
    end
  end

  // State and output registers. Reset parks everything in the idle,
  // bus-released condition, abandoning any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_lb_n_q  <= 1'b1;
      sram_ub_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_ce_n_q  <= sram_ce_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_lb_n_q  <= sram_lb_n_d;
      sram_ub_n_q  <= sram_ub_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_ce_n  = sram_ce_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_lb_n  = sram_lb_n_q;
  assign sram_ub_n  = sram_ub_n_q;

endmodule

// File: tb/tb_dlx_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dlx_sram_ctrl
//
// Drives dlx_sram_ctrl against a behavioural 16-bit SRAM model. Each request
// pushes its expected outcome (data word, ack latency, strobe cycle counts)
// into a queue; a monitor pops one entry per ack and compares. The reference
// memory is kept as 32-bit words with byte-enable merging.
// ---------------------------------------------------------------------------
module tb_dlx_sram_ctrl;

  localparam int ADDR_W = 19;
  localparam int W      = 2;

  typedef struct {
    logic        is_write;
    int          addr;
    logic [31:0] word;
    int          latency;
    int          oe_cyc;
    int          we_cyc;
    int          drive_cyc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              busy;
  logic [ADDR_W:0]   sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_lb_n;
  logic              sram_ub_n;

  int          errors = 0;
  int          checks = 0;
  int          acks_seen = 0;
  int          viol = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          oe_cnt = 0;
  int          we_cnt = 0;
  int          drv_cnt = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] sram_mem [256];
  logic [31:0] ref_words [128];

  dlx_sram_ctrl #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .be         (be),
    .wdata      (wdata),
    .rdata      (rdata),
    .ack        (ack),
    .busy       (busy),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_lb_n  (sram_lb_n),
    .sram_ub_n  (sram_ub_n)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Initial SRAM contents; two fixed words give the directed read its data
  function automatic logic [15:0] pat(input int h);
    if (h == 16) return 16'hBEEF;
    if (h == 17) return 16'hDEAD;
    return 16'((h * 947) + 453);
  endfunction

  // Asynchronous SRAM model: lanes are written while ce_n and we_n are low,
  // reads return data only on enabled lanes and junk otherwise
  initial begin
    for (int h = 0; h < 256; h++) sram_mem[h] = pat(h);
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
        if (!sram_lb_n) sram_mem[sram_addr[7:0]][7:0]  = sram_dq_o[7:0];
        if (!sram_ub_n) sram_mem[sram_addr[7:0]][15:8] = sram_dq_o[15:8];
      end
    end
  end

  // Read path of the SRAM model
  always_comb begin
    sram_dq_i = 16'h0BAD;
    if (!sram_ce_n && !sram_oe_n) begin
      sram_dq_i[7:0]  = sram_lb_n ? 8'hAD : sram_mem[sram_addr[7:0]][7:0];
      sram_dq_i[15:8] = sram_ub_n ? 8'h0B : sram_mem[sram_addr[7:0]][15:8];
    end
  end

  // One comparison: count it, report it if it differs
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Word-level reference: merge bytes on writes, predict timing from halves
  task automatic modelAccess(input logic w, input int a, input logic [3:0] b,
                             input logic [31:0] d, output exp_t e);
    int n;
    n = 0;
    e.is_write = w;
    e.addr     = a;
    if (w) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) ref_words[a][8*k +: 8] = d[8*k +: 8];
      end
      if (b[1:0] != 2'b00) n++;
      if (b[3:2] != 2'b00) n++;
      e.latency   = 1 + n * (W + 1);
      e.oe_cyc    = 0;
      e.we_cyc    = n * W;
      e.drive_cyc = n * (W + 1);
    end else begin
      e.latency   = 3 + 2 * W;
      e.oe_cyc    = 2 * W;
      e.we_cyc    = 0;
      e.drive_cyc = 0;
    end
    e.word = ref_words[a];
  endtask

  task automatic waitAck(input int target);
    for (int i = 0; i < 100 && acks_seen < target; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("ack_wait", acks_seen, target);
  endtask

  // Single request: req for one cycle, then scramble the captured inputs
  task automatic applyStimulus(input logic w, input int a, input logic [3:0] b,
                               input logic [31:0] d);
    exp_t e;
    int   target;
    modelAccess(w, a, b, d, e);
    exp_q.push_back(e);
    target = acks_seen + 1;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = ADDR_W'(a); be = b; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = ADDR_W'($urandom_range(0, 127));
    be = 4'($urandom); wdata = $urandom;
    waitAck(target);
  endtask

  // Two reads of the same word with req held through the first ack
  task automatic applyBackToBack(input int a);
    exp_t e;
    int   target;
    modelAccess(1'b0, a, 4'hF, 32'h0, e);
    exp_q.push_back(e);
    exp_q.push_back(e);
    target = acks_seen + 2;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = ADDR_W'(a); be = 4'hF;
    for (int i = 0; i < 100 && !ack; i++) @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    waitAck(target);
  endtask

  // Read with stray write requests pulsed while the controller is busy
  task automatic applyBusy(input int a);
    exp_t e;
    int   target;
    modelAccess(1'b0, a, 4'hF, 32'h0, e);
    exp_q.push_back(e);
    target = acks_seen + 1;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = ADDR_W'(a); be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = ADDR_W'($urandom_range(0, 63));
      be = 4'hF; wdata = $urandom;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    waitAck(target);
    repeat (3) @(negedge clk);
    checkOutput("busy_after_single_ack", {31'd0, busy}, 32'd0);
    checkOutput("acks_after_busy", acks_seen, target);
  endtask

  // Write aborted by reset in its first upper-half strobe cycle
  task automatic applyResetMidWrite(input int a);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = ADDR_W'(a); be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rst_mid_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_mid_ce_n", {31'd0, sram_ce_n}, 32'd1);
  endtask

  // Monitor: tracks acceptance and strobe activity, scores every ack
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      oe_cnt  = 0;
      we_cnt  = 0;
      drv_cnt = 0;
    end else begin
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dq_oe && !sram_oe_n) viol++;
      if (!sram_ce_n && (sram_addr[ADDR_W:8] != '0)) viol++;
      if (!sram_ce_n && !sram_oe_n) oe_cnt++;
      if (!sram_ce_n && !sram_we_n) we_cnt++;
      if (sram_dq_oe) drv_cnt++;
      if (ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("latency", cyc - accept_cyc, mon_e.latency);
          if (mon_e.is_write) begin
            checkOutput("sram_word",
                        {sram_mem[2*mon_e.addr+1], sram_mem[2*mon_e.addr]},
                        mon_e.word);
          end else begin
            checkOutput("rdata", rdata, mon_e.word);
          end
          checkOutput("oe_cycles", oe_cnt, mon_e.oe_cyc);
          checkOutput("we_cycles", we_cnt, mon_e.we_cyc);
          checkOutput("drive_cycles", drv_cnt, mon_e.drive_cyc);
        end
        oe_cnt  = 0;
        we_cnt  = 0;
        drv_cnt = 0;
        acks_seen++;
      end
      if (req && !busy) accept_cyc = cyc;
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = 4'h0;
    wdata = 32'h0;
    for (int w = 0; w < 128; w++) ref_words[w] = {pat(2*w + 1), pat(2*w)};

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ack", {31'd0, ack}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    checkOutput("reset_strobes",
                {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n},
                32'h1F);
    checkOutput("reset_sram_addr", {12'd0, sram_addr}, 32'd0);
    checkOutput("reset_dq_o", {16'd0, sram_dq_o}, 32'd0);

    $display("[TB] directed read / write / partial writes");
    applyStimulus(1'b0, 8, 4'hF, 32'h0);
    applyStimulus(1'b1, 4, 4'hF, 32'h12345678);
    applyStimulus(1'b0, 4, 4'hF, 32'h0);
    applyStimulus(1'b1, 5, 4'b0010, 32'hAABBCCDD);
    applyStimulus(1'b1, 6, 4'b0000, 32'h11223344);
    applyStimulus(1'b1, 7, 4'b1000, 32'h99887766);
    applyStimulus(1'b0, 5, 4'hF, 32'h0);
    applyStimulus(1'b0, 6, 4'hF, 32'h0);
    applyStimulus(1'b0, 7, 4'hF, 32'h0);

    $display("[TB] busy and back-to-back");
    applyBusy(3);
    applyBackToBack(4);

    $display("[TB] reset during write");
    applyResetMidWrite(100);
    applyStimulus(1'b0, 9, 4'hF, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      if ((i % 8) == 7) begin
        applyBackToBack($urandom_range(0, 63));
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                      4'($urandom), $urandom);
      end
    end
    for (int a = 0; a < 8; a++) applyStimulus(1'b0, a, 4'hF, 32'h0);

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("invariants", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
